// File: rtl/bshift_pkg.sv
// bshift_pkg: shared mode encoding and latency helper for the pipelined barrel shifter
package bshift_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ROL = 2'b10,
        ASR = 2'b11
    } shift_mode_e;

    function automatic int lat_f(input int amt_w, input int reg_every);
        return (amt_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/bshift_stage.sv
// bshift_stage: one combinational log stage shifting or rotating by a fixed SHIFT when enabled
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int WIDTH = 136,
    parameter int SHIFT = 1
) (
    input  logic             en,
    input  shift_mode_e      mode,
    input  logic             sign,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int ROT = SHIFT % WIDTH;

    logic [WIDTH-1:0] lsl, lsr, rol, asr, keep;

    assign lsl  = d << SHIFT;
    assign lsr  = d >> SHIFT;
    assign rol  = (d << ROT) | (d >> (WIDTH - ROT));
    assign keep = {WIDTH{1'b1}} >> SHIFT;
    assign asr  = lsr | (sign ? ~keep : '0);

    // Pick the shifted form for the active mode; a clear amount bit passes the word through
    always_comb
        q = !en           ? d   :
            mode == LSL   ? lsl :
            mode == LSR   ? lsr :
            mode == ROL   ? rol : asr;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined log barrel shifter with valid/ready flow control and a sideband tag
module barrel_shifter_pipe
    import bshift_pkg::*;
#(
    parameter int WIDTH     = 136,
    parameter int O_WIDTH   = 64,
    parameter int AMT_W     = 7,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_word,
    input  logic [AMT_W-1:0]   i_amt,
    input  logic [1:0]         i_mode,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [O_WIDTH-1:0] o_word,
    output logic [TAG_W-1:0]   o_tag,
    output logic [2:0]         o_inflight
);

    localparam int LAT = lat_f(AMT_W, REG_EVERY);

    logic             adv;
    logic [LAT-1:0]   r_valid, seg_valid, r_sign, seg_sign;
    logic [WIDTH-1:0] r_word [LAT];
    logic [WIDTH-1:0] seg_word [LAT];
    logic [AMT_W-1:0] r_amt [LAT];
    logic [AMT_W-1:0] seg_amt [LAT];
    shift_mode_e      r_mode [LAT];
    shift_mode_e      seg_mode [LAT];
    logic [TAG_W-1:0] r_tag [LAT];
    logic [TAG_W-1:0] seg_tag [LAT];
    logic [WIDTH-1:0] st_in [AMT_W];
    logic [WIDTH-1:0] st_out [AMT_W];

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Each segment takes its control from the inputs or the previous register slice
    for (genvar s = 0; s < LAT; s++) begin : g_seg
        localparam int LAST = (((s + 1) * REG_EVERY > AMT_W) ? AMT_W : (s + 1) * REG_EVERY) - 1;
        if (s == 0) begin : g_head
            assign seg_valid[s] = i_valid;
            assign seg_sign[s]  = i_word[WIDTH-1];
            assign seg_amt[s]   = i_amt;
            assign seg_mode[s]  = shift_mode_e'(i_mode);
            assign seg_tag[s]   = i_tag;
        end else begin : g_body
            assign seg_valid[s] = r_valid[s-1];
            assign seg_sign[s]  = r_sign[s-1];
            assign seg_amt[s]   = r_amt[s-1];
            assign seg_mode[s]  = r_mode[s-1];
            assign seg_tag[s]   = r_tag[s-1];
        end
        assign seg_word[s] = st_out[LAST];
    end

    // Stage k shifts by 2^k, fed by the previous stage or the register slice ahead of it
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_in[k] = i_word;
        end else if (k % REG_EVERY == 0) begin : g_reg
            assign st_in[k] = r_word[k/REG_EVERY-1];
        end else begin : g_chain
            assign st_in[k] = st_out[k-1];
        end
        bshift_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
            .en  (seg_amt[k/REG_EVERY][k]),
            .mode(seg_mode[k/REG_EVERY]),
            .sign(seg_sign[k/REG_EVERY]),
            .d   (st_in[k]),
            .q   (st_out[k])
        );
    end

    // Whole pipe advances in lockstep when the output slot is free or being drained
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_valid <= '0;
            r_sign  <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_word[s] <= '0;
                r_amt[s]  <= '0;
                r_mode[s] <= LSL;
                r_tag[s]  <= '0;
            end
        end else if (adv) begin
            r_valid <= seg_valid;
            r_sign  <= seg_sign;
            for (int s = 0; s < LAT; s++) begin
                r_word[s] <= seg_word[s];
                r_amt[s]  <= seg_amt[s];
                r_mode[s] <= seg_mode[s];
                r_tag[s]  <= seg_tag[s];
            end
        end

    assign o_valid    = r_valid[LAT-1];
    assign o_tag      = r_tag[LAT-1];
    assign o_inflight = 3'($countones(r_valid));
    assign o_word     = (r_mode[LAT-1] == LSL || r_mode[LAT-1] == ROL)
                        ? r_word[LAT-1][WIDTH-1 -: O_WIDTH]
                        : r_word[LAT-1][O_WIDTH-1:0];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed checks of shift modes, latency, stalls and reset on two configurations
module tb_barrel_shifter_pipe;
    import bshift_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0, i_ready = 1'b1, o_ready, o_valid;
    logic [135:0] i_word = '0;
    logic [6:0]   i_amt = '0;
    logic [1:0]   i_mode = '0;
    logic [7:0]   i_tag = '0, o_tag;
    logic [63:0]  o_word;
    logic [2:0]   o_inflight;

    logic         s_valid = 1'b0, s_ready = 1'b1, s_oready, s_ovalid;
    logic [15:0]  s_word = '0;
    logic [4:0]   s_amt = '0;
    logic [1:0]   s_mode = '0;
    logic [7:0]   s_tag = '0, s_otag;
    logic [7:0]   s_oword;
    logic [2:0]   s_inflight;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    barrel_shifter_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_word(i_word), .i_amt(i_amt), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_word(o_word), .o_tag(o_tag),
        .o_inflight(o_inflight)
    );

    barrel_shifter_pipe #(.WIDTH(16), .O_WIDTH(8), .AMT_W(5), .REG_EVERY(1), .TAG_W(8)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_oready),
        .i_word(s_word), .i_amt(s_amt), .i_mode(s_mode), .i_tag(s_tag),
        .o_valid(s_ovalid), .i_ready(s_ready), .o_word(s_oword), .o_tag(s_otag),
        .o_inflight(s_inflight)
    );

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input string name, input logic [135:0] w, input logic [6:0] a,
                        input logic [1:0] m, input logic [7:0] t, input logic [63:0] exp);
        int n;
        @(negedge clk);
        i_valid = 1'b1; i_word = w; i_amt = a; i_mode = m; i_tag = t;
        n = 0;
        do begin
            @(posedge clk); #1 i_valid = 1'b0; n++;
            @(negedge clk);
        end while (!o_valid && n < 20);
        check({name, "_lat"}, n, 4);
        check(name, o_word, exp);
        check({name, "_tag"}, o_tag, t);
    endtask

    task automatic beat_s(input string name, input logic [15:0] w, input logic [4:0] a,
                          input logic [1:0] m, input logic [7:0] exp);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_word = w; s_amt = a; s_mode = m; s_tag = 8'h3C;
        n = 0;
        do begin
            @(posedge clk); #1 s_valid = 1'b0; n++;
            @(negedge clk);
        end while (!s_ovalid && n < 20);
        check({name, "_lat"}, n, 5);
        check(name, s_oword, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rcv, peak;
        logic held;
        logic [63:0] prev_word;
        logic [7:0] prev_tag;
        logic stale;

        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_word", o_word, 0);
        check("rst_tag", o_tag, 0);
        check("rst_inflight", o_inflight, 0);
        check("rst_ready", o_ready, 1);
        rst = 1'b0;

        beat("lsl8", {8'h0, 64'h0123456789ABCDEF, 64'h0}, 7'd8, LSL, 8'h11, 64'h0123456789ABCDEF);
        beat("lsr4", 136'hF0, 7'd4, LSR, 8'h12, 64'h0F);
        beat("asr127", {9'h1FF, 127'h0}, 7'd127, ASR, 8'h13, 64'hFFFF_FFFF_FFFF_FFFF);
        beat("rol72", {72'h0, 64'hDEADBEEFCAFEF00D}, 7'd72, ROL, 8'h14, 64'hDEADBEEFCAFEF00D);
        beat("lsr0", 136'h12345, 7'd0, LSR, 8'h15, 64'h12345);
        beat("lsl127", {136{1'b1}}, 7'd127, LSL, 8'h16, 64'hFF80_0000_0000_0000);
        beat("asr72pos", {8'h7F, 128'h0}, 7'd72, ASR, 8'h17, 64'h7F00_0000_0000_0000);
        beat("rol0", {8'hAB, 128'h0}, 7'd0, ROL, 8'h18, 64'hAB00_0000_0000_0000);

        repeat (2) @(negedge clk);
        rcv = 0; peak = 0; held = 1'b0; prev_word = '0; prev_tag = '0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    i_valid = 1'b1;
                    i_word = 136'({8'(i), 8'h5A}) << 1;
                    i_amt = 7'd1; i_mode = LSR; i_tag = 8'(i);
                    k = 0;
                    while (!o_ready && k < 20) begin @(negedge clk); k++; end
                    @(negedge clk);
                end
                i_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
            begin
                for (int c = 0; c < 60 && rcv < 6; c++) begin
                    @(negedge clk);
                    if (o_inflight > peak) peak = o_inflight;
                    if (o_valid && !i_ready) begin
                        check("stall_oready", o_ready, 0);
                        if (held) begin
                            check("stall_word", o_word, prev_word);
                            check("stall_tag", o_tag, prev_tag);
                        end
                        held = 1'b1; prev_word = o_word; prev_tag = o_tag;
                    end else held = 1'b0;
                    if (o_valid && i_ready) begin
                        rcv++;
                        check("stream_tag", o_tag, rcv);
                        check("stream_word", o_word, {48'h0, 8'(rcv), 8'h5A});
                    end
                end
            end
        join
        check("stream_count", rcv, 6);
        check("stream_peak", peak, 4);
        @(negedge clk);
        check("stream_drained", o_inflight, 0);

        i_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_word = 136'hAA; i_amt = 7'd0; i_mode = LSR; i_tag = 8'(8'h40 + i);
        end
        @(negedge clk);
        i_valid = 1'b0;
        k = 0;
        while (!o_valid && k < 20) begin @(negedge clk); k++; end
        check("pre_rst_valid", o_valid, 1);
        check("pre_rst_inflight", o_inflight, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_inflight", o_inflight, 0);
        check("mid_rst_word", o_word, 0);
        check("mid_rst_tag", o_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid || o_inflight != 0) stale = 1'b1;
        end
        check("post_rst_stale", stale, 0);

        beat_s("s_lsl17", 16'h8001, 5'd17, LSL, 8'h00);
        beat_s("s_rol17", 16'h8001, 5'd17, ROL, 8'h00);
        beat_s("s_asr17", 16'h8001, 5'd17, ASR, 8'hFF);
        beat_s("s_lsr17", 16'h8001, 5'd17, LSR, 8'h00);
        beat_s("s_rol9", 16'h8001, 5'd9, ROL, 8'h03);
        beat_s("s_asr4", 16'h8000, 5'd4, ASR, 8'h00);
        beat_s("s_lsl3", 16'h0123, 5'd3, LSL, 8'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
